serial_subtractor_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. It computes diff = a - b by sequencing one shared full_subtractor cell over WIDTH cycles, LSB first, and carries the borrow between bits in a register. It sits beside full_subtractor as the reuse path for multi-bit subtraction where area matters more than latency. The host side uses a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor_ctrl.sv | 106 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared FSM state encoding and counter sizing for the bit-serial subtractor.
// No logic, no latency; consumed by serial_subtractor_ctrl.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; never below 1 so WIDTH=1 still gets a counter.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
// Purely combinational, no latency, no flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b over one shared full_subtractor, LSB first; done WIDTH+1 edges after start.
// start is only sampled in IDLE; requests during SHIFT/DONE are dropped, never queued.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_diff;
    logic             r_bi;
    logic             r_borrow;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_part_next;

    full_subtractor u_cell (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .bi (r_bi),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last = (r_count == CW'(WIDTH - 1));

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_part_next = (r_part >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_part   <= '0;
            r_diff   <= '0;
            r_bi     <= 1'b0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == SHIFT) && w_last;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_part  <= '0;
                        r_bi    <= 1'b0;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_part  <= w_part_next;
                    r_bi    <= w_bo;
                    r_count <= r_count + 1'b1;
                    // Outputs only move here so no partial result is ever visible.
                    if (w_last) begin
                        r_diff   <= w_part_next;
                        r_borrow <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboarded random/directed bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor_ctrl;

    typedef struct {
        int         unit;
        logic [7:0] d;
        logic       bw;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       a1, b1;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    logic       busy1, done1, borrow1;
    logic       diff1;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         edge_n = 0;
    bit         mon_en = 1'b0;
    logic [7:0] held_d[2];
    logic       held_b[2];
    int         busy_lo[2];
    int         busy_hi[2];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (u == 0) begin
            start8 = s; a8 = a; b8 = b;
        end else begin
            start1 = s; a1 = a[0]; b1 = b[0];
        end
    endtask

    // Reference: unsigned a - b mod 2^W, borrow when a < b; done W edges after acceptance.
    task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b,
                         input int mode, input logic [7:0] ha, input logic [7:0] hb);
        int         w;
        int         k;
        logic [7:0] m;
        exp_t       e;
        w = (u == 0) ? 8 : 1;
        m = (u == 0) ? 8'hFF : 8'h01;
        k = edge_n + 1;
        drive(u, 1'b1, a, b);
        e.unit = u;
        e.d    = (a - b) & m;
        e.bw   = ((a & m) < (b & m));
        e.cyc  = k + w;
        sb.push_back(e);
        busy_lo[u] = k;
        busy_hi[u] = k + w - 1;
        @(posedge clk); #1;
        while (edge_n <= k + w) begin
            case (mode)
                1:       drive(u, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                2:       drive(u, 1'b1, ha, hb);
                default: drive(u, 1'b0, 8'($urandom), 8'($urandom));
            endcase
            @(posedge clk); #1;
        end
        drive(u, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic reset_mid();
        int k;
        k = edge_n + 1;
        drive(0, 1'b1, 8'h77, 8'h22);
        busy_lo[0] = k;
        busy_hi[0] = k + 7;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            held_d[u]  = 8'h00;
            held_b[u]  = 1'b0;
            busy_lo[u] = 1;
            busy_hi[u] = 0;
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic       bz, dn, bw;
        logic [7:0] df;
        exp_t       e;
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                bz = (u == 0) ? busy8 : busy1;
                dn = (u == 0) ? done8 : done1;
                bw = (u == 0) ? borrow8 : borrow1;
                df = (u == 0) ? diff8 : {7'b0, diff1};
                check(u == 0 ? "busy8" : "busy1", 32'(bz),
                      32'(edge_n >= busy_lo[u] && edge_n <= busy_hi[u]));
                if (dn === 1'b1) begin
                    if (sb.size() == 0 || sb[0].unit != u) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done unit %0d at edge %0d", u, edge_n);
                    end else begin
                        e = sb.pop_front();
                        check("diff", 32'(df), 32'(e.d));
                        check("borrow", 32'(bw), 32'(e.bw));
                        check("done_edge", edge_n, e.cyc);
                        held_d[u] = e.d;
                        held_b[u] = e.bw;
                    end
                end else begin
                    check("done_low", 32'(dn), 32'd0);
                    check("diff_hold", 32'(df), 32'(held_d[u]));
                    check("borrow_hold", 32'(bw), 32'(held_b[u]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        for (int u = 0; u < 2; u++) begin
            held_d[u]  = 8'h00;
            held_b[u]  = 1'b0;
            busy_lo[u] = 1;
            busy_hi[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        check("rst_borrow8", 32'(borrow8), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        issue(0, 8'h5A, 8'h3C, 0, 8'h00, 8'h00);
        issue(0, 8'h00, 8'h01, 0, 8'h00, 8'h00);
        issue(0, 8'hFF, 8'hFF, 0, 8'h00, 8'h00);
        issue(0, 8'h80, 8'h7F, 0, 8'h00, 8'h00);
        // start held high across the op with operands changed mid-flight
        issue(0, 8'h10, 8'h01, 2, 8'hAA, 8'h55);
        issue(0, 8'hAA, 8'h55, 0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) issue(0, 8'($urandom), 8'($urandom), 1, 8'h00, 8'h00);

        reset_mid();
        issue(0, 8'h33, 8'h44, 0, 8'h00, 8'h00);

        for (int i = 0; i < 30; i++) begin
            issue(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 8'h00, 8'h00);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 4; i++) begin
            issue(1, 8'(i >> 1), 8'(i & 1), 0, 8'h00, 8'h00);
        end
        for (int i = 0; i < 10; i++) begin
            issue(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 8'h00, 8'h00);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
